// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions: datapath words, register/offset fields,
// control word and the IF/ID queue entry.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;
  typedef logic [10:0] lc3b_offset11;

  typedef struct packed {
    logic [3:0] opcode;
    logic [2:0] aluop;
    logic       load_regfile;
    logic       load_cc;
    logic       mem_read;
    logic       mem_write;
    logic [4:0] muxsel;
  } lc3b_control_word;

  // One decoded instruction as held between fetch and decode.
  typedef struct packed {
    lc3b_word         pc;
    lc3b_control_word ctrl_word;
    lc3b_reg          dest;
    lc3b_reg          src1;
    lc3b_reg          src2;
    lc3b_word         offset6;
    lc3b_word         offset9;
    lc3b_offset11     offset11;
    lc3b_word         imm5;
  } lc3b_ifid_entry;

endpackage

// File: rtl/lc3b_fifo.sv
// Generic DEPTH-entry FIFO with occupancy count and synchronous flush.
// Flush clears pointers and count and cancels any same-cycle push or pop.
module lc3b_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [15:0]
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  T                             data_i,
  output T                             data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok_s;
  logic             push_ok_s;

  // A pop of an empty FIFO is ignored; a push into a full FIFO only lands
  // when a pop frees the head slot in the same cycle.
  assign pop_ok_s  = pop_i && (count_q != '0);
  assign push_ok_s = push_i && ((count_q != FULL_CNT) || pop_ok_s);

  // Next pointer and occupancy values; flush overrides push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      else           wr_ptr_d = wr_ptr_q;
      if (pop_ok_s)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      else           rd_ptr_d = rd_ptr_q;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful where count covers them.
  always_ff @(posedge clk) begin
    if (push_ok_s && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifid_queue.sv
// IF/ID decoupling stage: fetch FSM issuing memory requests, decode of the
// returned instruction into fields, and a FIFO presenting the oldest entry
// to the ID stage over a valid/ready handshake.
module ifid_queue
  import lc3b_types::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_resp,
  input  lc3b_word         instr,
  input  lc3b_word         pc_in,
  input  lc3b_control_word ctrl_word_in,
  input  lc3b_word         offset6_in,
  input  lc3b_word         offset9_in,
  input  logic             flush,
  input  logic             out_ready,
  output logic             mem_request,
  output logic             load_pc,
  output logic             out_valid,
  output lc3b_word         pc,
  output lc3b_word         offset6_out,
  output lc3b_word         offset9_out,
  output lc3b_word         imm5,
  output lc3b_reg          dest,
  output lc3b_reg          src1,
  output lc3b_reg          src2,
  output lc3b_offset11     offset11,
  output lc3b_control_word ctrl_word_out,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RESP = 2'd1,
    DROP      = 2'd2
  } fetch_state_e;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_state_e     state_q, state_d;
  logic             load_pc_q, load_pc_d;
  logic             push_s;
  logic             pop_s;
  logic [CNT_W-1:0] count_s;
  lc3b_ifid_entry   entry_s;
  lc3b_ifid_entry   head_s;
  lc3b_ifid_entry   view_s;
  logic             opcode_unused_s;

  // The opcode bits only reach decode through the control word.
  assign opcode_unused_s = &instr[15:12];

  assign out_valid = (count_s != '0);
  assign pop_s     = out_valid && out_ready;

  // Split the returned instruction into decode fields at push time.
  always_comb begin
    entry_s           = '0;
    entry_s.pc        = pc_in;
    entry_s.ctrl_word = ctrl_word_in;
    entry_s.dest      = instr[11:9];
    entry_s.src1      = instr[8:6];
    entry_s.src2      = instr[2:0];
    entry_s.offset6   = offset6_in;
    entry_s.offset9   = offset9_in;
    entry_s.offset11  = instr[10:0];
    entry_s.imm5      = {{11{instr[4]}}, instr[4:0]};
  end

  // Fetch state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Fetch next state; a request reserves a slot, counting a same-cycle pop
  // as freeing one so a full queue resumes fetching on the popping edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!flush && ((count_s != FULL_CNT) || pop_s)) state_d = WAIT_RESP;
        else                                             state_d = IDLE;
      end
      WAIT_RESP: begin
        if (mem_resp)   state_d = IDLE;
        else if (flush) state_d = DROP;
        else            state_d = WAIT_RESP;
      end
      DROP: begin
        if (flush)         state_d = DROP;
        else if (mem_resp) state_d = IDLE;
        else               state_d = DROP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetch outputs: request level, push of an accepted response, PC advance.
  always_comb begin
    mem_request = (state_q != IDLE);
    push_s      = (state_q == WAIT_RESP) && mem_resp && !flush;
    load_pc_d   = push_s;
  end

  // load_pc is a registered one-cycle pulse after the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) load_pc_q <= 1'b0;
    else        load_pc_q <= load_pc_d;
  end

  assign load_pc = load_pc_q;

  lc3b_fifo #(
    .DEPTH (DEPTH),
    .T     (lc3b_ifid_entry)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (entry_s),
    .data_o  (head_s),
    .count_o (count_s)
  );

  // Head fields are visible only while an entry is valid, zero otherwise.
  always_comb begin
    view_s = '0;
    if (out_valid) view_s = head_s;
    else           view_s = '0;
  end

  assign pc            = view_s.pc;
  assign ctrl_word_out = view_s.ctrl_word;
  assign dest          = view_s.dest;
  assign src1          = view_s.src1;
  assign src2          = view_s.src2;
  assign offset6_out   = view_s.offset6;
  assign offset9_out   = view_s.offset9;
  assign offset11      = view_s.offset11;
  assign imm5          = view_s.imm5;
  assign count         = count_s;

endmodule
